// File: rtl/morse_game_pkg.sv
// Shared encodings for the Morse memory game controller: FSM states,
// the blank display symbol and the BCD digit ceiling.
package morse_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RECONFIG   = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_SHOW       = 3'd3,
        ST_ENTRY      = 3'd4,
        ST_DECIDE     = 3'd5,
        ST_GAMEOVER   = 3'd6
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // All-ones pattern of width w; the display treats it as "blank".
    function automatic logic [31:0] blank_sym(input int unsigned w);
        if (w >= 32) return '1;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// Multi-digit packed BCD up-counter with ripple carry that sticks at all-9s.
module bcd_sat_counter
    import morse_game_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] nxt;
    logic                carry;
    logic                all_nine;

    always_comb begin
        nxt      = value;
        carry    = 1'b1;
        all_nine = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (value[4*d +: 4] != BCD_MAX) all_nine = 1'b0;
            if (carry) begin
                if (value[4*d +: 4] == BCD_MAX) begin
                    nxt[4*d +: 4] = 4'd0;
                end else begin
                    nxt[4*d +: 4] = value[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc && !all_nine) begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/morse_game_ctrl_n.sv
// Morse memory game round controller: shows SEQ_LEN symbols, collects the
// user's entries, scores the round and handles game-over / logout.
module morse_game_ctrl_n
    import morse_game_pkg::*;
#(
    parameter int SEQ_LEN      = 2,
    parameter int SYM_W        = 4,
    parameter int SHOW_CYCLES  = 250000000,
    parameter int SCORE_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      logged_in,
    input  logic                      game_start,
    input  logic                      logout,
    input  logic                      timeout,
    input  logic [SYM_W-1:0]          sym_in,
    input  logic                      load,
    input  logic [SYM_W-1:0]          user_input,
    output logic                      reconfig,
    output logic                      enable,
    output logic [SYM_W-1:0]          number,
    output logic                      show_valid,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic                      correct,
    output logic                      round_done,
    output logic                      logout_ack
);

    localparam int IDX_W = $clog2(SEQ_LEN + 1);
    localparam int BUF_N = 1 << IDX_W;
    localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [SYM_W-1:0] BLANK     = SYM_W'(blank_sym(SYM_W));
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_LEN - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(SHOW_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] timer;
    logic             mismatch;
    logic [SYM_W-1:0] seq_buf [BUF_N];

    logic in_game;
    logic start_cfg;
    logic accept_logout;
    logic score_clr;
    logic score_inc;

    assign in_game       = (state == ST_SHOW) || (state == ST_ENTRY) || (state == ST_DECIDE);
    assign accept_logout = (state == ST_GAMEOVER) && logout;
    assign start_cfg     = ((state == ST_IDLE) && logged_in) ||
                           ((state == ST_GAMEOVER) && !logout && game_start);
    // Score clears on the edge entering RECONFIG, and on logout so IDLE shows zero.
    assign score_clr     = start_cfg || accept_logout;
    assign score_inc     = (state == ST_DECIDE) && !timeout && !mismatch;

    bcd_sat_counter #(.DIGITS(SCORE_DIGITS)) u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (score_clr),
        .inc   (score_inc),
        .value (score)
    );

    // Symbols are captured on the edge that starts their slot, so each one is
    // on the display for exactly SHOW_CYCLES cycles while timer runs 0..max.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            timer      <= '0;
            mismatch   <= 1'b0;
            for (int i = 0; i < BUF_N; i++) seq_buf[i] <= '0;
            reconfig   <= 1'b0;
            enable     <= 1'b0;
            number     <= '0;
            show_valid <= 1'b0;
            correct    <= 1'b0;
            round_done <= 1'b0;
            logout_ack <= 1'b0;
        end else begin
            reconfig   <= 1'b0;
            round_done <= 1'b0;
            logout_ack <= 1'b0;
            if (timeout && in_game) begin
                state      <= ST_GAMEOVER;
                enable     <= 1'b0;
                number     <= '0;
                show_valid <= 1'b0;
                idx        <= '0;
                timer      <= '0;
                mismatch   <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (logged_in) begin
                            state    <= ST_RECONFIG;
                            reconfig <= 1'b1;
                            correct  <= 1'b0;
                        end
                    end
                    ST_RECONFIG: state <= ST_WAIT_START;
                    ST_WAIT_START: begin
                        if (game_start) begin
                            state      <= ST_SHOW;
                            enable     <= 1'b1;
                            show_valid <= 1'b1;
                            idx        <= '0;
                            timer      <= '0;
                            number     <= sym_in;
                            seq_buf[0] <= sym_in;
                        end
                    end
                    ST_SHOW: begin
                        if (timer == LAST_TICK) begin
                            timer <= '0;
                            if (idx < LAST_IDX) begin
                                idx                        <= idx + IDX_W'(1);
                                seq_buf[idx + IDX_W'(1)]   <= sym_in;
                                number                     <= sym_in;
                            end else begin
                                idx        <= '0;
                                number     <= BLANK;
                                show_valid <= 1'b0;
                                state      <= ST_ENTRY;
                            end
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    ST_ENTRY: begin
                        if (load) begin
                            if (user_input != seq_buf[idx]) mismatch <= 1'b1;
                            idx <= idx + IDX_W'(1);
                            if (idx == LAST_IDX) state <= ST_DECIDE;
                        end
                    end
                    ST_DECIDE: begin
                        correct    <= !mismatch;
                        round_done <= 1'b1;
                        mismatch   <= 1'b0;
                        idx        <= '0;
                        timer      <= '0;
                        state      <= ST_SHOW;
                        show_valid <= 1'b1;
                        number     <= sym_in;
                        seq_buf[0] <= sym_in;
                    end
                    ST_GAMEOVER: begin
                        if (logout) begin
                            logout_ack <= 1'b1;
                            correct    <= 1'b0;
                            state      <= ST_IDLE;
                        end else if (game_start) begin
                            reconfig <= 1'b1;
                            correct  <= 1'b0;
                            state    <= ST_RECONFIG;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_game_ctrl_n.sv
// Bench for morse_game_ctrl_n: scripted and randomized rounds checked against
// a score/sequence model kept as plain integers and arrays.
module tb_morse_game_ctrl_n;

    localparam int SEQ_LEN      = 2;
    localparam int SYM_W        = 4;
    localparam int SHOW_CYCLES  = 4;
    localparam int SCORE_DIGITS = 2;

    logic       clk = 1'b0;
    logic       rst, logged_in, game_start, logout, timeout, load;
    logic [3:0] sym_in, user_input;
    logic       reconfig, enable, show_valid, correct, round_done, logout_ack;
    logic [3:0] number;
    logic [7:0] score;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_score = 0;
    logic exp_correct = 1'b0;
    logic logout_noise = 1'b0;

    logic [3:0] s_q [SEQ_LEN];
    logic [3:0] n_q [SEQ_LEN];
    logic [3:0] u_q [SEQ_LEN];

    always #5 clk = ~clk;

    morse_game_ctrl_n #(
        .SEQ_LEN(SEQ_LEN), .SYM_W(SYM_W), .SHOW_CYCLES(SHOW_CYCLES), .SCORE_DIGITS(SCORE_DIGITS)
    ) dut (
        .clk(clk), .rst(rst), .logged_in(logged_in), .game_start(game_start), .logout(logout),
        .timeout(timeout), .sym_in(sym_in), .load(load), .user_input(user_input),
        .reconfig(reconfig), .enable(enable), .number(number), .show_valid(show_valid),
        .score(score), .correct(correct), .round_done(round_done), .logout_ack(logout_ack)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1);
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] rand_sym();
        return 4'($urandom_range(0, 14));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_next();
        for (int k = 0; k < SEQ_LEN; k++) n_q[k] = rand_sym();
    endtask

    task automatic make_entries(input bit match);
        for (int k = 0; k < SEQ_LEN; k++) u_q[k] = s_q[k];
        if (!match) begin
            int j;
            j = $urandom_range(0, SEQ_LEN - 1);
            u_q[j] = s_q[j] + 4'($urandom_range(1, 15));
        end
    endtask

    // From WAIT_START: starts the game; returns in the first SHOW cycle.
    task automatic start_game();
        sym_in     = s_q[0];
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
    endtask

    task automatic login_and_start();
        logged_in = 1'b1;
        tick();
        n_checks++;
        if ({reconfig, score, correct} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL login_reconfig: got reconfig=%b score=%h correct=%b, expected 1 00 0",
                     reconfig, score, correct);
        end
        tick();
        n_checks++;
        if (reconfig !== 1'b0) begin
            n_fail++;
            $display("FAIL reconfig_one_cycle: got %b expected 0", reconfig);
        end
        exp_score   = 0;
        exp_correct = 1'b0;
        start_game();
    endtask

    task automatic play_show();
        for (int k = 0; k < SEQ_LEN; k++) begin
            for (int c = 0; c < SHOW_CYCLES; c++) begin
                n_checks++;
                if ({show_valid, enable, logout_ack, number} !== {3'b110, s_q[k]}) begin
                    n_fail++;
                    $display("FAIL show_sym%0d_c%0d: got valid=%b en=%b ack=%b num=%h, expected 1 1 0 %h",
                             k, c, show_valid, enable, logout_ack, number, s_q[k]);
                end
                if (c == 0 && k < SEQ_LEN - 1) sym_in = s_q[k + 1];
                logout = logout_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
                tick();
            end
        end
        logout = 1'b0;
        n_checks++;
        if ({show_valid, enable, number} !== {2'b01, 4'hF}) begin
            n_fail++;
            $display("FAIL show_blank: got valid=%b en=%b num=%h, expected 0 1 f",
                     show_valid, enable, number);
        end
    endtask

    task automatic play_entry(input bit gaps, input bit timeout_last);
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    n_checks++;
                    if ({round_done, show_valid, number} !== {2'b00, 4'hF}) begin
                        n_fail++;
                        $display("FAIL entry_idle: got done=%b valid=%b num=%h, expected 0 0 f",
                                 round_done, show_valid, number);
                    end
                end
            end
            user_input = u_q[k];
            load       = 1'b1;
            if (k == SEQ_LEN - 1 && timeout_last) timeout = 1'b1;
            tick();
            load    = 1'b0;
            timeout = 1'b0;
        end
    endtask

    // In DECIDE: scores the round against the model, returns in next SHOW.
    task automatic play_decide();
        bit match;
        match = 1'b1;
        for (int k = 0; k < SEQ_LEN; k++) if (u_q[k] != s_q[k]) match = 1'b0;
        n_checks++;
        if (round_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_early: got %b expected 0", round_done);
        end
        sym_in = n_q[0];
        tick();
        exp_correct = match;
        if (match && exp_score < 99) exp_score++;
        n_checks++;
        if ({round_done, correct, score} !== {1'b1, exp_correct, to_bcd(exp_score)}) begin
            n_fail++;
            $display("FAIL round_result: got done=%b correct=%b score=%h, expected 1 %b %h",
                     round_done, correct, score, exp_correct, to_bcd(exp_score));
        end
        n_checks++;
        if ({show_valid, number} !== {1'b1, n_q[0]}) begin
            n_fail++;
            $display("FAIL next_round_show: got valid=%b num=%h, expected 1 %h",
                     show_valid, number, n_q[0]);
        end
        for (int k = 0; k < SEQ_LEN; k++) s_q[k] = n_q[k];
    endtask

    task automatic test_reset();
        rst = 1'b1; logged_in = 1'b0; game_start = 1'b0; logout = 1'b0;
        timeout = 1'b0; load = 1'b0; sym_in = 4'h0; user_input = 4'h0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({reconfig, enable, show_valid, correct, round_done, logout_ack, number, score}
            !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rc=%b en=%b v=%b c=%b d=%b ack=%b num=%h score=%h, expected all 0",
                     reconfig, enable, show_valid, correct, round_done, logout_ack, number, score);
        end
        tick();
        n_checks++;
        if (reconfig !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_login: got reconfig=%b expected 0", reconfig);
        end
    endtask

    task automatic test_round_correct();
        s_q[0] = 4'h3; s_q[1] = 4'h7;
        login_and_start();
        play_show();
        u_q[0] = 4'h3; u_q[1] = 4'h7;
        play_entry(1'b0, 1'b0);
        n_q[0] = 4'h3; n_q[1] = 4'h7;
        play_decide();
    endtask

    task automatic test_round_wrong();
        play_show();
        u_q[0] = 4'h3; u_q[1] = 4'h5;
        play_entry(1'b0, 1'b0);
        gen_next();
        play_decide();
    endtask

    task automatic test_saturation();
        int rounds;
        int sat_rounds;
        rounds = 0;
        sat_rounds = 0;
        logout_noise = 1'b1;
        while (rounds < 300 && sat_rounds < 2) begin
            bit match;
            match = ($urandom_range(0, 9) < 8);
            if (match && exp_score == 99) sat_rounds++;
            play_show();
            make_entries(match);
            play_entry(1'b1, 1'b0);
            gen_next();
            play_decide();
            rounds++;
        end
        logout_noise = 1'b0;
        n_checks++;
        if (sat_rounds < 2 || score !== 8'h99) begin
            n_fail++;
            $display("FAIL saturation: got score=%h after %0d rounds, expected 99 held", score, rounds);
        end
    endtask

    task automatic test_timeout_final_load();
        make_entries(1'b1);
        play_show();
        play_entry(1'b0, 1'b1);
        n_checks++;
        if ({enable, show_valid, round_done, number} !== 7'h0) begin
            n_fail++;
            $display("FAIL timeout_gameover: got en=%b v=%b done=%b num=%h, expected 0 0 0 0",
                     enable, show_valid, round_done, number);
        end
        n_checks++;
        if ({score, correct} !== {to_bcd(exp_score), exp_correct}) begin
            n_fail++;
            $display("FAIL timeout_hold: got score=%h correct=%b, expected %h %b",
                     score, correct, to_bcd(exp_score), exp_correct);
        end
        tick();
        n_checks++;
        if ({round_done, enable, score} !== {2'b00, to_bcd(exp_score)}) begin
            n_fail++;
            $display("FAIL timeout_no_score: got done=%b en=%b score=%h, expected 0 0 %h",
                     round_done, enable, score, to_bcd(exp_score));
        end
    endtask

    task automatic test_gameover_exit();
        logout = 1'b1; game_start = 1'b1; logged_in = 1'b0;
        tick();
        logout = 1'b0; game_start = 1'b0;
        n_checks++;
        if ({logout_ack, reconfig, score, correct} !== {2'b10, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL logout_wins: got ack=%b rc=%b score=%h correct=%b, expected 1 0 00 0",
                     logout_ack, reconfig, score, correct);
        end
        tick();
        n_checks++;
        if ({logout_ack, reconfig} !== 2'b00) begin
            n_fail++;
            $display("FAIL logout_pulse: got ack=%b rc=%b expected 0 0", logout_ack, reconfig);
        end
        for (int k = 0; k < SEQ_LEN; k++) s_q[k] = rand_sym();
        login_and_start();
        play_show();
        make_entries(1'b1);
        play_entry(1'b0, 1'b0);
        gen_next();
        play_decide();
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        n_checks++;
        if ({enable, show_valid, score} !== {2'b00, to_bcd(exp_score)}) begin
            n_fail++;
            $display("FAIL show_timeout: got en=%b v=%b score=%h, expected 0 0 %h",
                     enable, show_valid, score, to_bcd(exp_score));
        end
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        n_checks++;
        if ({reconfig, logout_ack, score, correct} !== {2'b10, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL restart: got rc=%b ack=%b score=%h correct=%b, expected 1 0 00 0",
                     reconfig, logout_ack, score, correct);
        end
        tick();
        n_checks++;
        if (reconfig !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_pulse: got rc=%b expected 0", reconfig);
        end
    endtask

    task automatic test_reset_mid_show();
        for (int k = 0; k < SEQ_LEN; k++) s_q[k] = rand_sym();
        start_game();
        tick(); tick();
        n_checks++;
        if ({show_valid, enable} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_show: got v=%b en=%b expected 1 1", show_valid, enable);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({reconfig, enable, show_valid, correct, round_done, logout_ack, number, score}
            !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_mid_show: got rc=%b en=%b v=%b c=%b d=%b ack=%b num=%h score=%h, expected all 0",
                     reconfig, enable, show_valid, correct, round_done, logout_ack, number, score);
        end
        tick();
        n_checks++;
        if (reconfig !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_to_idle: got reconfig=%b expected 1", reconfig);
        end
    endtask

    initial begin
        test_reset();
        test_round_correct();
        test_round_wrong();
        test_saturation();
        test_timeout_final_load();
        test_gameover_exit();
        test_reset_mid_show();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
